// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and helpers for the APB requester arbiter:
//               FSM state encoding, default bus widths, and counter sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

  // Transfer phases of the shared APB master port
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  localparam int c_DATA_W = 32;
  localparam int c_ADDR_W = 8;

  // Ceiling log2, usable at elaboration time
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Wait counter width: enough to hold TIMEOUT, never narrower than one bit
  function automatic int cnt_width(input int timeout);
    int w;
    w = clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : apb_rr_pick
// Description : Combinational round-robin picker. Returns the first active
//               requester after last_grant_i, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_pick #(
  parameter int NREQ  = 2,
  parameter int GNT_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GNT_W-1:0] last_grant_i,
  output logic [GNT_W-1:0] gnt_o,
  output logic             valid_o
);

  // Scan from farthest to nearest so the nearest active requester wins last
  always_comb begin
    int idx;
    idx     = 0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % NREQ;
      if (req_i[idx]) begin
        gnt_o   = GNT_W'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_req_arbiter
// Description : Round-robin arbiter sharing one APB master port between NREQ
//               requesters, with a wait-state watchdog on the ACCESS phase.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int ADDR_W  = c_ADDR_W,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   PSEL,
  output logic                   PEN,
  output logic                   PW,
  output logic [ADDR_W-1:0]      PADDR,
  output logic [DATA_W-1:0]      PWDATA,
  input  logic                   PREADY,
  input  logic [DATA_W-1:0]      PRDATA
);

  localparam int c_GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CNT_W = cnt_width(TIMEOUT);
  // Counter value seen during the last permitted ACCESS cycle
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit c_WDOG_EN = (TIMEOUT > 0);

  apb_state_e          state_q;
  logic [c_GNT_W-1:0]  gnt_q;       // doubles as the round-robin last_grant
  logic [c_CNT_W-1:0]  wait_cnt_q;
  logic [NREQ-1:0]     ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                busy_q;
  logic                psel_q;
  logic                pen_q;
  logic                pw_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;

  logic [c_GNT_W-1:0]  w_pick_gnt;
  logic                w_pick_valid;
  logic                w_pick_we;
  logic [ADDR_W-1:0]   w_pick_addr;
  logic [DATA_W-1:0]   w_pick_wdata;

  apb_rr_pick #(
    .NREQ  (NREQ),
    .GNT_W (c_GNT_W)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (gnt_q),
    .gnt_o        (w_pick_gnt),
    .valid_o      (w_pick_valid)
  );

  // Command lanes of the requester that would win this cycle
  assign w_pick_we    = req_we[w_pick_gnt];
  assign w_pick_addr  = req_addr[w_pick_gnt*ADDR_W +: ADDR_W];
  assign w_pick_wdata = req_wdata[w_pick_gnt*DATA_W +: DATA_W];

  // Transfer FSM; every output is a register so the bus never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= c_GNT_W'(NREQ - 1);
      wait_cnt_q <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      psel_q     <= 1'b0;
      pen_q      <= 1'b0;
      pw_q       <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_pick_valid) begin
            gnt_q    <= w_pick_gnt;
            psel_q   <= 1'b1;
            pen_q    <= 1'b0;
            pw_q     <= w_pick_we;
            paddr_q  <= w_pick_addr;
            pwdata_q <= w_pick_we ? w_pick_wdata : '0;
            busy_q   <= 1'b1;
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          pen_q   <= 1'b1;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            ack_q   <= NREQ'(1) << gnt_q;
            rdata_q <= pw_q ? '0 : PRDATA;
            err_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (c_WDOG_EN && (wait_cnt_q == c_CNT_LAST)) begin
            // Slave never answered: release the bus and report the abort
            psel_q  <= 1'b0;
            pen_q   <= 1'b0;
            ack_q   <= NREQ'(1) << gnt_q;
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q + c_CNT_W'(1);
          end
        end
        ST_DONE: begin
          ack_q      <= '0;
          wait_cnt_q <= '0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = busy_q;
  assign PSEL      = psel_q;
  assign PEN       = pen_q;
  assign PW        = pw_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_req_arbiter
// Description : Self-checking bench for apb_req_arbiter: reset, contention,
//               table-driven single transfers, random traffic against a
//               transaction-level model, and reset in the middle of ACCESS.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 8;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 15;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        req_we = '0;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   busy;
  logic                   PSEL;
  logic                   PEN;
  logic                   PW;
  logic [ADDR_W-1:0]      PADDR;
  logic [DATA_W-1:0]      PWDATA;
  logic                   PREADY;
  logic [DATA_W-1:0]      PRDATA;

  logic [ADDR_W-1:0] cmd_addr  [NREQ];
  logic [DATA_W-1:0] cmd_wdata [NREQ];

  int n_checks = 0;
  int n_errs   = 0;

  apb_req_arbiter #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .PSEL      (PSEL),
    .PEN       (PEN),
    .PW        (PW),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA)
  );

  always #5 clk = ~clk;

  // Pack per-requester command lanes
  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = cmd_addr[i];
      req_wdata[i*DATA_W +: DATA_W] = cmd_wdata[i];
    end
  end

  // ---------------- APB slave: memory with programmable wait states -------
  int          waits   = 0;
  logic        hang    = 1'b0;
  int          acc_cnt = 0;
  logic        mem_init = 1'b0;
  logic        pl_en    = 1'b0;
  logic [7:0]  pl_addr  = '0;
  logic [31:0] pl_data  = '0;
  logic [DATA_W-1:0] mem     [256];
  logic [DATA_W-1:0] ref_mem [256];

  function automatic logic [31:0] init_val(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b, b, b} ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign PREADY = PSEL && PEN && !hang && (acc_cnt >= waits);
  assign PRDATA = mem[PADDR];

  always @(posedge clk) begin
    acc_cnt <= (PSEL && PEN && !PREADY) ? acc_cnt + 1 : 0;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (PSEL && PEN && PREADY && PW) begin
      mem[PADDR] <= PWDATA;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- table-driven single transfers ------------------------
  typedef struct packed {
    int          lane;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        hang;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_pen;
  } vec_t;

  vec_t vecs [9];
  int   last_lane = 0;

  task automatic run_vec(input vec_t t);
    int pen_cnt;
    bit got;
    pen_cnt = 0;
    got     = 1'b0;
    waits   = t.waits;
    hang    = t.hang;
    req            = '0;
    req[t.lane]    = 1'b1;
    req_we[t.lane] = t.we;
    cmd_addr[t.lane]  = t.addr;
    cmd_wdata[t.lane] = t.wdata;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("setup_psel", PSEL, 1);
        chk("setup_pen", PEN, 0);
        chk("setup_busy", busy, 1);
      end
      if (PSEL) begin
        chk("bus_paddr", PADDR, t.addr);
        chk("bus_pw", PW, t.we);
        chk("bus_pwdata", PWDATA, t.we ? t.wdata : 32'h0);
      end
      if (PEN) pen_cnt++;
      if (ack != '0) begin
        got = 1'b1;
        chk("done_ack", ack, oh(t.lane));
        chk("done_rdata", rsp_rdata, t.exp_rdata);
        chk("done_err", rsp_err, t.exp_err);
        chk("done_psel", PSEL, 0);
        chk("pen_cycles", pen_cnt, t.exp_pen);
        req = '0;
      end
      if (c == 1) begin
        // Scramble the lanes: the latched command must keep driving the bus
        cmd_addr[t.lane]  = ~t.addr;
        cmd_wdata[t.lane] = ~t.wdata;
        req_we[t.lane]    = ~t.we;
      end
    end
    if (!got) chk("ack_timeout", 0, 1);
    req = '0;
    if (t.we && !t.exp_err) ref_mem[t.addr] = t.wdata;
    last_lane = t.lane;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_ack", ack, 0);
    chk("hold_rdata", rsp_rdata, t.exp_rdata);
  endtask

  // Global bound in case the design stalls inside a hand sequence
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    int n_ack, last_c, n_setup;
    logic psel_prev;
    int exp_gnt;
    logic t_we, t_hang;
    logic [7:0] t_addr;
    logic [31:0] t_wdata;
    int n_rnd_acks;
    bit got;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    cmd_addr[0] = 8'h20; cmd_addr[1] = 8'h21;
    cmd_wdata[0] = 32'h0; cmd_wdata[1] = 32'h0;

    // ---- reset held for 2 cycles with both requests pending ----
    rst = 1'b1; req = 2'b11; req_we = 2'b00; mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_pen", PEN, 0);
    chk("rst_pw", PW, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    pl_en = 1'b1; pl_addr = 8'h02; pl_data = 32'hcafecafe;
    ref_mem[8'h02] = 32'hcafecafe;
    @(negedge clk);
    pl_en = 1'b0;
    rst = 1'b0;

    // ---- contention: both requests held, strict rotation 0,1,0,1 ----
    n_ack = 0; n_setup = 0; last_c = 0; psel_prev = 1'b0;
    waits = 0; hang = 1'b0;
    for (int c = 1; c <= 30 && n_ack < 4; c++) begin
      @(negedge clk);
      if (PSEL && !psel_prev) begin
        chk("cont_paddr", PADDR, cmd_addr[n_setup % 2]);
        n_setup++;
      end
      if (ack != '0) begin
        chk("cont_order", ack, oh(n_ack % 2));
        chk("cont_rdata", rsp_rdata, ref_mem[cmd_addr[n_ack % 2]]);
        if (n_ack == 0) chk("cont_first_ack_cycle", c, 3);
        else            chk("cont_ack_gap", c - last_c, 4);
        last_c = c;
        n_ack++;
        if (n_ack == 4) req = '0;
      end
      psel_prev = PSEL;
    end
    chk("cont_acks", n_ack, 4);
    last_lane = 1;
    @(negedge clk);

    // ---- table-driven single transfers ----
    vecs[0] = '{0, 1'b0, 8'h02, 32'h0,         0,  1'b0, 32'hcafecafe, 1'b0, 1};
    vecs[1] = '{1, 1'b1, 8'h10, 32'h12345678,  3,  1'b0, 32'h0,        1'b0, 4};
    vecs[2] = '{1, 1'b0, 8'h10, 32'h0,         1,  1'b0, 32'h12345678, 1'b0, 2};
    vecs[3] = '{0, 1'b0, 8'h33, 32'h0,         0,  1'b1, 32'h0,        1'b1, 15};
    vecs[4] = '{0, 1'b0, 8'h02, 32'h0,         0,  1'b0, 32'hcafecafe, 1'b0, 1};
    vecs[5] = '{0, 1'b1, 8'hff, 32'ha5a5a5a5, 14,  1'b0, 32'h0,        1'b0, 15};
    vecs[6] = '{1, 1'b0, 8'hff, 32'h0,         2,  1'b0, 32'ha5a5a5a5, 1'b0, 3};
    vecs[7] = '{1, 1'b1, 8'h02, 32'h0,         0,  1'b1, 32'h0,        1'b1, 15};
    vecs[8] = '{0, 1'b0, 8'h02, 32'h0,         0,  1'b0, 32'hcafecafe, 1'b0, 1};
    for (int v = 0; v < 9; v++) run_vec(vecs[v]);

    // ---- random traffic against a transaction-level model ----
    psel_prev = PSEL; exp_gnt = 0; n_rnd_acks = 0;
    t_we = 1'b0; t_hang = 1'b0; t_addr = '0; t_wdata = '0;
    req = '0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clk);
      if (PSEL && !psel_prev) begin
        int w;
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          if (w < 0 && req[(last_lane + k) % NREQ]) w = (last_lane + k) % NREQ;
        end
        if (w < 0) begin
          chk("rnd_spurious_setup", PSEL, 0);
        end else begin
          exp_gnt = w; last_lane = w;
          t_we = req_we[w]; t_addr = cmd_addr[w]; t_wdata = cmd_wdata[w];
          chk("rnd_paddr", PADDR, t_addr);
          chk("rnd_pw", PW, t_we);
          chk("rnd_pwdata", PWDATA, t_we ? t_wdata : 32'h0);
          t_hang = ($urandom_range(0, 15) == 0);
          hang   = t_hang;
          waits  = $urandom_range(0, 5);
        end
      end
      if (ack != '0) begin
        chk("rnd_ack", ack, oh(exp_gnt));
        chk("rnd_err", rsp_err, t_hang);
        chk("rnd_rdata", rsp_rdata, (t_we || t_hang) ? 32'h0 : ref_mem[t_addr]);
        if (t_we && !t_hang) ref_mem[t_addr] = t_wdata;
        req[exp_gnt] = 1'b0;
        n_rnd_acks++;
      end
      if (cyc < 3000) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req[i] && $urandom_range(0, 3) == 0) begin
            req[i]       = 1'b1;
            req_we[i]    = 1'($urandom);
            cmd_addr[i]  = 8'($urandom_range(0, 15));
            cmd_wdata[i] = $urandom;
          end
        end
      end else if (req == '0 && !busy) begin
        break;
      end
      psel_prev = PSEL;
    end
    chk("rnd_progress", (n_rnd_acks > 100) ? 1 : 0, 1);
    chk("rnd_drained", {busy, req}, 0);

    // ---- reset asserted between edges during ACCESS ----
    req = '0; hang = 1'b1; req_we = '0;
    cmd_addr[0] = 8'h44;
    @(negedge clk);
    req[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (PEN) got = 1'b1;
    end
    chk("mr_reach_access", got, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_psel", PSEL, 0);
    chk("mr_pen", PEN, 0);
    chk("mr_ack", ack, 0);
    chk("mr_busy", busy, 0);
    cmd_addr[0] = 8'h55; cmd_addr[1] = 8'h66;
    req = 2'b11; hang = 1'b0; waits = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_setup_psel", PSEL, 1);
    chk("mr_first_paddr", PADDR, 8'h55);
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1'b1;
        chk("mr_first_ack", ack, 2'b01);
        req = '0;
      end
    end
    chk("mr_ack_seen", got, 1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
Shares one APB master port between NREQ requesters, for example a CPU-side command port and a DMA/config sequencer. The block arbitrates round-robin and latches the winner's command. It then runs the APB SETUP/ACCESS sequence on PSEL/PEN/PW/PADDR/PWDATA and returns read data, completion and error to the granted requester. A wait-state watchdog stops a slave that never asserts PREADY from locking up the bus.

Parameters:
DATA_W, 32, APB data width (PWDATA/PRDATA/req_wdata lanes)
ADDR_W, 8, APB address width (PADDR/req_addr lanes)
NREQ, 2, number of requesters (2..4)
TIMEOUT, 15, maximum ACCESS cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request, level-held until its ack
req_we  in  NREQ  per-requester direction: 1 = write, 0 = read
req_addr  in  NREQ*ADDR_W  per-requester address, lane i = bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NREQ*DATA_W  per-requester write data, lane i likewise
ack  out  NREQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  DATA_W  read data, valid while any ack bit is high
rsp_err  out  1  timeout abort flag, valid while any ack bit is high
busy  out  1  high in SETUP, ACCESS and DONE
PSEL  out  1  APB select
PEN  out  1  APB enable
PW  out  1  APB write (1) / read (0)
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PREADY  in  1  APB slave ready
PRDATA  in  DATA_W  APB read data

Behaviour:
- Clock and reset: single clock domain. clk/rst reset is asynchronous, active-high.
- Reset values: all outputs 0. FSM goes to IDLE. Wait counter is 0. Round-robin pointer last_grant = NREQ-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE:
  - When any req is high, pick the first requester after last_grant, wrapping modulo NREQ.
  - Latch that requester's we/addr/wdata, store its index in gnt, set last_grant = gnt, go to SETUP.
  - No req high: stay in IDLE.
- SETUP (exactly 1 cycle): PSEL=1, PEN=0, PW=we_latched, PADDR=addr_latched. PWDATA=wdata_latched on writes, 0 on reads. Next state ACCESS.
- ACCESS: PSEL=1, PEN=1; PW/PADDR/PWDATA stay stable.
  - PREADY high at the edge: on reads capture PRDATA into rsp_rdata (writes leave 0). rsp_err=0, go to DONE.
  - PREADY low: increment the wait counter.
  - TIMEOUT>0 and counter == TIMEOUT-1 with PREADY still low: abort. rsp_rdata=0, rsp_err=1, go to DONE.
  - So ACCESS lasts at most TIMEOUT cycles.
- DONE (1 cycle): PSEL=0, PEN=0, ack[gnt]=1, other ack bits 0. Clear the wait counter. Next state IDLE.
  - The requester drops or changes req at the edge ending DONE.
  - A req still high in IDLE is a new transfer.
- Transfer length and rotation: minimum 4 cycles per transfer (SETUP, ACCESS, DONE, IDLE). Continuous requests from all requesters are served in strict rotation.
- Register holding:
  - PADDR, PW and PWDATA hold their last values in DONE/IDLE (reset 0).
  - rsp_rdata and rsp_err hold until the next DONE.
- Timing rules:
  - req changes during SETUP/ACCESS are ignored because the command is already latched.
  - Requests that arrive in DONE are first seen in IDLE.
- Reset mid-transfer: PSEL/PEN fall immediately, without waiting for a clock. No ack is issued; the requester must re-request.

Decomposition:
- Shared package apb_pkg:
  - state encoding (2-bit: IDLE=0, SETUP=1, ACCESS=2, DONE=3);
  - default DATA_W/ADDR_W constants;
  - clog2 helper for the wait counter width, clog2(TIMEOUT+1).
- One sub-module, apb_rr_pick: combinational round-robin picker. Inputs req[NREQ] and last_grant; outputs gnt index and a valid flag. Instantiated in the IDLE decision.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req=2'b11 -> all outputs 0, no ack, busy=0; first grant after release goes to requester 0.
2. Single read: req[0]=1, addr 0x02, slave returns 0xcafecafe with PREADY=PSEL&&PEN -> PSEL=1 PEN=0 in cycle 1, PEN=1 in cycle 2, ack=2'b01 in cycle 3 with rsp_rdata=0xcafecafe, rsp_err=0.
3. Contention: req=2'b11 held continuously -> grant order 0,1,0,1; each ack 4 cycles apart; PADDR alternates between lane 0 and lane 1 addresses.
4. Write with waits: req[1] write, addr 0x10, data 0x12345678, PREADY low for 3 ACCESS cycles -> PEN high 4 cycles; PW=1, PADDR=0x10, PWDATA=0x12345678 stable throughout; then ack=2'b10.
5. Timeout: TIMEOUT=15, PREADY tied 0 -> PEN high exactly 15 cycles, then PSEL/PEN=0; ack with rsp_err=1, rsp_rdata=0. The next request completes normally with rsp_err=0.
6. Reset mid-ACCESS: assert rst between clock edges -> PSEL/PEN fall the same instant, no ack. After release with req=2'b11, requester 0 is granted first.
